rect_plot_arbiter: RTL and testbench
====================================

# rect_plot_arbiter

- Shares the single VGA pixel-write port (`VGA_X`/`VGA_Y`/`VGA_COLOR`/`plot`) of the animation top level among up to `NREQ` rectangle requesters (tile eraser, tile drawer, score/hit-bar painter, background).
- Grants one request at a time, round-robin.
- Rasterises the granted solid rectangle at one pixel per clock and pulses a per-requester `done`.
- Sits between the game-logic FSMs and the VGA adapter, replacing ad-hoc muxing of plot signals.

## Interface

Parameters:
- `NREQ`, 4: number of requesters.
- `XW`, 8: x coordinate/width bits (160x120 mode).
- `YW`, 7: y coordinate/height bits.
- `CW`, 24: colour bits.
- `XMAX`, 160: visible width; pixels with x ≥ `XMAX` are clipped.
- `YMAX`, 120: visible height; pixels with y ≥ `YMAX` are clipped.

Ports:
- `CLOCK_50`, in, 1: sole clock, rising edge.
- `resetn`, in, 1: asynchronous, active-low reset.
- `req`, in, `NREQ`: level request, one bit per requester.
- `rx`, in, `NREQ*XW`: left x per requester; requester i at bits [i*XW +: XW].
- `ry`, in, `NREQ*YW`: top y per requester.
- `rw`, in, `NREQ*XW`: width in pixels.
- `rh`, in, `NREQ*YW`: height in pixels.
- `rcolor`, in, `NREQ*CW`: fill colour.
- `gnt`, out, `NREQ`: one-hot, one-cycle pulse; marks the cycle the request's parameters were latched.
- `done`, out, `NREQ`: one-hot, one-cycle pulse after the requester's last pixel cycle.
- `busy`, out, 1: high in every state except IDLE.
- `VGA_X`, out, `XW`: pixel x.
- `VGA_Y`, out, `YW`: pixel y.
- `VGA_COLOR`, out, `CW`: pixel colour.
- `plot`, out, 1: write enable to the VGA adapter.

## Operation

- All outputs are registered.
- Reset values: `gnt`=0, `done`=0, `busy`=0, `plot`=0, `VGA_X`=0, `VGA_Y`=0, `VGA_COLOR`=0; round-robin pointer=0; state=IDLE.
- States:
  - IDLE: if `req` ≠ 0, select the first set bit searching upward from the pointer (wrapping). Latch that requester's x0, y0, w, h, colour. Pulse `gnt[i]`. Clear col/row counters. Set pointer = (i+1) mod `NREQ`. Go to DRAW. If `req` = 0, stay in IDLE.
  - DRAW: each cycle output one pixel: `VGA_X` = x0+col, `VGA_Y` = y0+row, `VGA_COLOR` = latched colour.
    - `plot` = 1 unless the pixel is clipped.
    - Scan is row-major: col increments; at col = w−1, col←0 and row increments.
    - After the pixel with row = h−1 and col = w−1, go to DONE.
  - DONE: `plot`=0, pulse `done[i]`, go to IDLE.
- Zero-size request (w=0 or h=0): granted normally; DRAW is skipped (IDLE→DONE); zero plots.
- Arithmetic and clipping:
  - x0+col is computed in XW+1 bits and y0+row in YW+1 bits.
  - A pixel is clipped if the sum ≥ `XMAX`/`YMAX` or overflows.
  - A clipped pixel still consumes its cycle with `plot`=0 and coordinates unchanged from the previous cycle.
- Requester contract:
  - Hold `req` and parameters stable until `gnt` is seen.
  - Parameter changes after `gnt` have no effect on the current draw.
  - `req` still high when the arbiter next returns to IDLE is a new request.
- `req` changes during DRAW/DONE are ignored until IDLE.
- `req` bits ≥ `NREQ` do not exist; `NREQ`=1 degenerates to fixed grant.
- Reset asserted mid-DRAW: the draw is abandoned immediately, all outputs go to reset values, no `done` is issued, pointer=0.

## Timing

- With `req[i]` high in IDLE sampled at edge k:
  - `gnt[i]` is high after edge k.
  - The first pixel is on outputs after edge k+1.
  - Pixel n (0-based) is on outputs after edge k+1+n.
  - `done[i]` is high after edge k+1+w·h; IDLE after edge k+2+w·h.
  - The earliest next `gnt` is after edge k+2+w·h.
- Throughput: w·h+2 cycles per rectangle (2 for zero-size).
- `busy` rises with `gnt` and falls the cycle after `done`.
- No combinational path from any input to any output.

## Test plan

- **Single 2x2 rectangle.** Only `req[1]`, (10,5), w=2, h=2, colour 24'hFF0000, req at edge 0:
  - `gnt`=4'b0010 after edge 0.
  - Plots (10,5), (11,5), (10,6), (11,6) after edges 1–4, colour FF0000.
  - `done`=4'b0010 after edge 5; `busy` low after edge 6.
- **Round-robin fairness.** From reset, `req`=4'b0101 held continuously, 1x1 rectangles:
  - Grant order is 0,2,0,2 at 3-cycle spacing.
  - Then with pointer=3, `req`=4'b1001 gives grant 3 before 0.
- **Zero size.** w=0, h=5 on `req[0]`:
  - `gnt` after edge 0, `done` after edge 1.
  - `plot` never high.
- **Clipping.** (158,118), w=4, h=4:
  - 16 draw cycles.
  - `plot` high only for (158,118), (159,118), (158,119), (159,119).
  - `done` after edge 17.
- **Reset mid-draw.** 10x10 draw; `resetn` low asynchronously at pixel 37:
  - All outputs 0 within the same cycle; no `done`.
  - After release, `req`=4'b0011 grants requester 0 first.
- **Parameter change after grant.** Change `rcolor` and `rx` one cycle after `gnt`:
  - The whole rectangle uses the originally latched values.

Source files
------------

// File: rtl/rect_plot_arbiter.sv
// Round-robin arbiter that shares one VGA pixel-write port among
// rectangle requesters, filling the granted rectangle one pixel per clock.
module rect_plot_arbiter #(
  parameter int NREQ = 4,
  parameter int XW   = 8,
  parameter int YW   = 7,
  parameter int CW   = 24,
  parameter int XMAX = 160,
  parameter int YMAX = 120
) (
  input  logic               CLOCK_50,
  input  logic               resetn,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ*XW-1:0] rx,
  input  logic [NREQ*YW-1:0] ry,
  input  logic [NREQ*XW-1:0] rw,
  input  logic [NREQ*YW-1:0] rh,
  input  logic [NREQ*CW-1:0] rcolor,
  output logic [NREQ-1:0]    gnt,
  output logic [NREQ-1:0]    done,
  output logic               busy,
  output logic [XW-1:0]      VGA_X,
  output logic [YW-1:0]      VGA_Y,
  output logic [CW-1:0]      VGA_COLOR,
  output logic               plot
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [XW:0] XLIM = (XW+1)'(XMAX);
  localparam logic [YW:0] YLIM = (YW+1)'(YMAX);

  typedef enum logic [1:0] {IDLE, DRAW, DONE} state_t;

  state_t          state, nxt;
  logic [PW-1:0]   ptr, sel, pick, ptr_nxt;
  logic            found, zero, last;
  logic [XW-1:0]   x0, w, col;
  logic [YW-1:0]   y0, h, row;
  logic [CW-1:0]   color;
  logic [XW:0]     sx;
  logic [YW:0]     sy;
  logic            clip;
  logic [XW-1:0]   pw;
  logic [YW-1:0]   ph;

  always_comb begin
    int idx;
    idx   = 0;
    found = 1'b0;
    pick  = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(ptr) + k) % NREQ;
      if (!found && req[idx]) begin
        found = 1'b1;
        pick  = PW'(idx);
      end
    end
  end

  assign pw      = rw[int'(pick)*XW +: XW];
  assign ph      = rh[int'(pick)*YW +: YW];
  assign zero    = (pw == '0) || (ph == '0);
  assign ptr_nxt = (pick == PW'(NREQ-1)) ? '0 : pick + 1'b1;

  assign sx   = {1'b0, x0} + {1'b0, col};
  assign sy   = {1'b0, y0} + {1'b0, row};
  // Top bit set means the sum left the coordinate range entirely.
  assign clip = sx[XW] || sy[YW] || (sx >= XLIM) || (sy >= YLIM);
  assign last = (col == w - 1'b1) && (row == h - 1'b1);

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE: if (found) nxt = zero ? DONE : DRAW;
      DRAW: if (last) nxt = DONE;
      DONE: nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      state     <= IDLE;
      ptr       <= '0;
      sel       <= '0;
      x0        <= '0;
      y0        <= '0;
      w         <= '0;
      h         <= '0;
      color     <= '0;
      col       <= '0;
      row       <= '0;
      gnt       <= '0;
      done      <= '0;
      busy      <= 1'b0;
      plot      <= 1'b0;
      VGA_X     <= '0;
      VGA_Y     <= '0;
      VGA_COLOR <= '0;
    end else begin
      state <= nxt;
      gnt   <= '0;
      done  <= '0;
      unique case (state)
        IDLE: begin
          plot <= 1'b0;
          busy <= found;
          if (found) begin
            gnt   <= NREQ'(1) << pick;
            sel   <= pick;
            ptr   <= ptr_nxt;
            x0    <= rx[int'(pick)*XW +: XW];
            y0    <= ry[int'(pick)*YW +: YW];
            w     <= pw;
            h     <= ph;
            color <= rcolor[int'(pick)*CW +: CW];
            col   <= '0;
            row   <= '0;
          end
        end
        DRAW: begin
          busy <= 1'b1;
          plot <= !clip;
          if (!clip) begin
            VGA_X     <= sx[XW-1:0];
            VGA_Y     <= sy[YW-1:0];
            VGA_COLOR <= color;
          end
          if (col == w - 1'b1) begin
            col <= '0;
            row <= row + 1'b1;
          end else begin
            col <= col + 1'b1;
          end
        end
        DONE: begin
          busy <= 1'b1;
          plot <= 1'b0;
          done <= NREQ'(1) << sel;
        end
        default: begin
          plot <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rect_plot_arbiter.sv
// Directed bench for rect_plot_arbiter: vector table plus
// round-robin, reset-mid-draw and parameter-change sequences.
module tb_rect_plot_arbiter;

  logic          CLOCK_50 = 1'b0;
  logic          resetn;
  logic [3:0]    req;
  logic [31:0]   rx, rw;
  logic [27:0]   ry, rh;
  logic [95:0]   rcolor;
  logic [3:0]    gnt, done;
  logic          busy, plot;
  logic [7:0]    VGA_X;
  logic [6:0]    VGA_Y;
  logic [23:0]   VGA_COLOR;

  int tests = 0;
  int fails = 0;

  rect_plot_arbiter dut (
    .CLOCK_50(CLOCK_50), .resetn(resetn), .req(req),
    .rx(rx), .ry(ry), .rw(rw), .rh(rh), .rcolor(rcolor),
    .gnt(gnt), .done(done), .busy(busy),
    .VGA_X(VGA_X), .VGA_Y(VGA_Y), .VGA_COLOR(VGA_COLOR), .plot(plot)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  typedef struct {
    int          idx;
    int          x, y, w, h;
    logic [23:0] c;
    int          plots, lat;
    int          fx, fy, lx, ly;
  } vec_t;

  vec_t vt[8];

  task automatic tick();
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_rect(int i, int x, int y, int w, int h,
                          logic [23:0] c);
    rx[i*8 +: 8]      = 8'(x);
    ry[i*7 +: 7]      = 7'(y);
    rw[i*8 +: 8]      = 8'(w);
    rh[i*7 +: 7]      = 7'(h);
    rcolor[i*24 +: 24] = c;
  endtask

  task automatic run_vec(vec_t v, int t);
    int n, np, bad, fx, fy, lx, ly;
    bit seen;
    n = 0; np = 0; bad = 0; seen = 0;
    fx = -1; fy = -1; lx = -1; ly = -1;
    set_rect(v.idx, v.x, v.y, v.w, v.h, v.c);
    req = 4'(1 << v.idx);
    tick();
    check($sformatf("v%0d_gnt", t), gnt, 64'(1 << v.idx));
    req = '0;
    while (!seen && n < 400) begin
      tick();
      n++;
      if (plot) begin
        if (VGA_COLOR !== v.c || VGA_X >= 160 || VGA_Y >= 120) bad++;
        if (np == 0) begin fx = VGA_X; fy = VGA_Y; end
        lx = VGA_X; ly = VGA_Y;
        np++;
      end
      if (done != 0) begin
        seen = 1;
        check($sformatf("v%0d_done", t), done, 64'(1 << v.idx));
        check($sformatf("v%0d_busy_done", t), busy, 1);
      end
    end
    check($sformatf("v%0d_latency", t), n, v.lat);
    check($sformatf("v%0d_plots", t), np, v.plots);
    check($sformatf("v%0d_bad_pixels", t), bad, 0);
    if (v.plots > 0) begin
      check($sformatf("v%0d_first", t), {fx, fy}, {v.fx, v.fy});
      check($sformatf("v%0d_last", t), {lx, ly}, {v.lx, v.ly});
    end
    tick();
    check($sformatf("v%0d_busy_low", t), busy, 0);
  endtask

  initial begin
    int exp_o[6];
    int gcount, cyc, lastc, np, bad;
    bit seen;

    vt[0] = '{1, 10, 5, 2, 2, 24'hFF0000, 4, 5, 10, 5, 11, 6};
    vt[1] = '{0, 0, 0, 0, 5, 24'h00FF00, 0, 1, 0, 0, 0, 0};
    vt[2] = '{2, 158, 118, 4, 4, 24'h0000FF, 4, 17, 158, 118, 159, 119};
    vt[3] = '{3, 0, 0, 1, 1, 24'h00FF00, 1, 2, 0, 0, 0, 0};
    vt[4] = '{0, 159, 119, 1, 1, 24'h123456, 1, 2, 159, 119, 159, 119};
    vt[5] = '{1, 250, 0, 10, 1, 24'hABCDEF, 0, 11, 0, 0, 0, 0};
    vt[6] = '{2, 5, 3, 3, 0, 24'h777777, 0, 1, 0, 0, 0, 0};
    vt[7] = '{3, 100, 100, 3, 2, 24'hC0FFEE, 6, 7, 100, 100, 102, 101};
    exp_o = '{0, 2, 0, 2, 3, 0};

    resetn = 1'b0;
    req = '0; rx = '0; ry = '0; rw = '0; rh = '0; rcolor = '0;
    #12;
    check("reset_outs", {gnt, done, busy, plot}, 0);
    check("reset_xyc", {VGA_X, VGA_Y, VGA_COLOR}, 0);
    @(negedge CLOCK_50);
    resetn = 1'b1;

    // Round-robin from reset pointer 0.
    for (int i = 0; i < 4; i++) set_rect(i, 1, 1, 1, 1, 24'h000001);
    req = 4'b0101;
    gcount = 0; cyc = 0; lastc = 0;
    while (gcount < 6 && cyc < 100) begin
      tick();
      cyc++;
      if (gnt != 0) begin
        check($sformatf("rr_order%0d", gcount), gnt,
              64'(1 << exp_o[gcount]));
        if (gcount > 0)
          check($sformatf("rr_gap%0d", gcount), cyc - lastc, 3);
        lastc = cyc;
        gcount++;
        if (gcount == 4) req = 4'b1001;
        if (gcount == 6) req = '0;
      end
    end
    check("rr_grants", gcount, 6);
    repeat (4) tick();

    for (int t = 0; t < 8; t++) run_vec(vt[t], t);

    // Parameters changed after grant must not affect the draw.
    set_rect(2, 30, 40, 3, 2, 24'h123456);
    req = 4'b0100;
    tick();
    check("pc_gnt", gnt, 4'b0100);
    req = '0;
    tick();
    check("pc_pix0", {plot, VGA_X, VGA_Y, VGA_COLOR},
          {1'b1, 8'd30, 7'd40, 24'h123456});
    np = 1; bad = 0; seen = 0; cyc = 0;
    set_rect(2, 0, 0, 3, 2, 24'hABCDEF);
    while (!seen && cyc < 50) begin
      tick();
      cyc++;
      if (plot) begin
        np++;
        if (VGA_X < 30 || VGA_X > 32 || VGA_COLOR !== 24'h123456) bad++;
      end
      if (done != 0) seen = 1;
    end
    check("pc_plots", np, 6);
    check("pc_bad", bad, 0);
    check("pc_done_cyc", cyc, 6);
    tick();

    // Reset asserted in the middle of a 10x10 draw by requester 0.
    set_rect(0, 20, 20, 10, 10, 24'h0000FF);
    req = 4'b0001;
    tick();
    check("rst_gnt", gnt, 4'b0001);
    req = '0;
    repeat (38) tick();
    check("rst_pix37", {plot, VGA_X, VGA_Y}, {1'b1, 8'd27, 7'd23});
    #2 resetn = 1'b0;
    #1;
    check("rst_async_outs", {gnt, done, busy, plot}, 0);
    check("rst_async_xyc", {VGA_X, VGA_Y, VGA_COLOR}, 0);
    set_rect(0, 1, 1, 1, 1, 24'h000001);
    set_rect(1, 2, 2, 1, 1, 24'h000002);
    req = 4'b0011;
    bad = 0;
    repeat (3) begin
      tick();
      if (done != 0 || busy) bad++;
    end
    check("rst_no_done", bad, 0);
    @(negedge CLOCK_50);
    resetn = 1'b1;
    tick();
    check("rst_ptr_gnt", gnt, 4'b0001);
    req = '0;
    repeat (4) tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
